// File: rtl/mdu_issue_queue.sv
// mdu_pkg: shared uop / physical-register types for the MDU issue path.
// mdu_issue_queue: in-order issue queue for multiply/divide uop pairs.
//   clk, rst          clock, asynchronous active-high reset
//   flush             drop every queued entry (reservations are kept)
//   enq_*             dispatch side: uop pair, two sources, source-ready flags
//   wake_valid/prf    two writeback broadcast ports used for source wakeup
//   uopHi/uopLo       registered pair presented to the MDU (NOP when idle)
//   rs0_addr/rs1_addr registered PRF read addresses of the issued pair
package mdu_pkg;
  typedef logic [5:0] PRFNum;

  typedef enum logic [3:0] {
    NOP_U,
    MULTHI_U, MULTLO_U, MULTUHI_U, MULTULO_U,
    DIVHI_U, DIVLO_U, DIVUHI_U, DIVULO_U
  } uop_e;

  typedef struct packed {
    logic       valid;
    uop_e       uOP;
    logic [7:0] id;
  } UOPBundle;
endpackage

module mdu_issue_queue
  import mdu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MUL_CYCLE = 4,
  parameter int DIV_CYCLE = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  UOPBundle    enq_uopHi,
  input  UOPBundle    enq_uopLo,
  input  PRFNum       enq_rs0,
  input  PRFNum       enq_rs1,
  input  logic        enq_rs0_rdy,
  input  logic        enq_rs1_rdy,
  input  logic [1:0]  wake_valid,
  input  PRFNum [1:0] wake_prf,
  output UOPBundle    uopHi,
  output UOPBundle    uopLo,
  output PRFNum       rs0_addr,
  output PRFNum       rs1_addr
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = DIV_CYCLE + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam UOPBundle NOP_UOP = '{valid: 1'b0, uOP: NOP_U, id: 8'd0};

  UOPBundle         ent_hi   [DEPTH];
  UOPBundle         ent_lo   [DEPTH];
  PRFNum            ent_rs0  [DEPTH];
  PRFNum            ent_rs1  [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_rdy0;
  logic [DEPTH-1:0] ent_rdy1;
  logic [DEPTH-1:0] ent_div;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [RW-1:0] resv;
  logic [RW-1:0] resv_next;

  logic     do_enq;
  logic     do_issue;
  logic     head_div;
  logic     resv_hit;
  logic     enq_div;
  UOPBundle issue_hi;
  UOPBundle issue_lo;

  function automatic logic wake_hit(input PRFNum r, input logic [1:0] v,
                                    input PRFNum [1:0] p);
    return (v[0] && (p[0] == r)) || (v[1] && (p[1] == r));
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    enq_ready = (count < FULL);
    do_enq    = enq_valid && enq_ready && !flush;
    enq_div   = (enq_uopLo.uOP == DIVLO_U) || (enq_uopLo.uOP == DIVULO_U);
    head_div  = ent_div[head];
    resv_hit  = head_div ? (resv[DIV_CYCLE] | resv[DIV_CYCLE+1])
                         : (resv[MUL_CYCLE] | resv[MUL_CYCLE+1]);
    do_issue  = ent_vld[head] && ent_rdy0[head] && ent_rdy1[head] &&
                !flush && !resv_hit;
    // Reservations are placed on the already-shifted vector so that bit i
    // refers to the cycle the issued pair first appears on the outputs.
    resv_next = resv >> 1;
    if (do_issue) begin
      if (head_div) begin
        resv_next[DIV_CYCLE]   = 1'b1;
        resv_next[DIV_CYCLE+1] = 1'b1;
      end else begin
        resv_next[MUL_CYCLE]   = 1'b1;
        resv_next[MUL_CYCLE+1] = 1'b1;
      end
    end
    issue_hi       = ent_hi[head];
    issue_hi.valid = 1'b1;
    issue_lo       = ent_lo[head];
    issue_lo.valid = 1'b1;
  end

  // Control state, reservations and registered issue outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_vld  <= '0;
      resv     <= '0;
      uopHi    <= NOP_UOP;
      uopLo    <= NOP_UOP;
      rs0_addr <= '0;
      rs1_addr <= '0;
    end else begin
      resv <= resv_next;
      if (do_issue) begin
        uopHi    <= issue_hi;
        uopLo    <= issue_lo;
        rs0_addr <= ent_rs0[head];
        rs1_addr <= ent_rs1[head];
      end else begin
        uopHi    <= NOP_UOP;
        uopLo    <= NOP_UOP;
        rs0_addr <= '0;
        rs1_addr <= '0;
      end
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        ent_vld <= '0;
      end else begin
        if (do_issue) begin
          ent_vld[head] <= 1'b0;
          head          <= ptr_inc(head);
        end
        if (do_enq) begin
          ent_vld[tail] <= 1'b1;
          tail          <= ptr_inc(tail);
        end
        case ({do_enq, do_issue})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_enq && (tail == PW'(i))) begin
        ent_hi[i]   <= enq_uopHi;
        ent_lo[i]   <= enq_uopLo;
        ent_rs0[i]  <= enq_rs0;
        ent_rs1[i]  <= enq_rs1;
        ent_div[i]  <= enq_div;
        ent_rdy0[i] <= enq_rs0_rdy | wake_hit(enq_rs0, wake_valid, wake_prf);
        ent_rdy1[i] <= enq_rs1_rdy | wake_hit(enq_rs1, wake_valid, wake_prf);
      end else begin
        ent_rdy0[i] <= ent_rdy0[i] | wake_hit(ent_rs0[i], wake_valid, wake_prf);
        ent_rdy1[i] <= ent_rdy1[i] | wake_hit(ent_rs1[i], wake_valid, wake_prf);
      end
    end
  end
endmodule

// File: tb/tb_mdu_issue_queue.sv
// Self-checking bench for mdu_issue_queue against a queue-based model that
// tracks writeback port occupancy as a set of absolute busy cycles.
module tb_mdu_issue_queue;
  import mdu_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MUL_CYCLE = 4;
  localparam int DIV_CYCLE = 18;
  localparam int OW = 2 * $bits(UOPBundle) + 2 * $bits(PRFNum);
  localparam UOPBundle NOPB = '{valid: 1'b0, uOP: NOP_U, id: 8'd0};
  localparam logic [OW-1:0] NOP_VEC = {NOPB, NOPB, 6'd0, 6'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  UOPBundle    enq_uopHi = '0;
  UOPBundle    enq_uopLo = '0;
  PRFNum       enq_rs0 = '0;
  PRFNum       enq_rs1 = '0;
  logic        enq_rs0_rdy = 1'b0;
  logic        enq_rs1_rdy = 1'b0;
  logic [1:0]  wake_valid = '0;
  PRFNum [1:0] wake_prf = '0;
  UOPBundle    uopHi;
  UOPBundle    uopLo;
  PRFNum       rs0_addr;
  PRFNum       rs1_addr;
  logic [OW-1:0] obs;

  assign obs = {uopHi, uopLo, rs0_addr, rs1_addr};

  mdu_issue_queue #(.DEPTH(DEPTH), .MUL_CYCLE(MUL_CYCLE), .DIV_CYCLE(DIV_CYCLE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_uopHi(enq_uopHi), .enq_uopLo(enq_uopLo),
    .enq_rs0(enq_rs0), .enq_rs1(enq_rs1),
    .enq_rs0_rdy(enq_rs0_rdy), .enq_rs1_rdy(enq_rs1_rdy),
    .wake_valid(wake_valid), .wake_prf(wake_prf),
    .uopHi(uopHi), .uopLo(uopLo), .rs0_addr(rs0_addr), .rs1_addr(rs1_addr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    UOPBundle hi;
    UOPBundle lo;
    PRFNum    rs0;
    PRFNum    rs1;
    bit       r0;
    bit       r1;
    bit       dv;
  } ment_t;

  ment_t         mq[$];
  bit            busy[int];
  logic [OW-1:0] exp_vec = NOP_VEC;
  int            cyc = 0;
  int            m_issues = 0;
  int            nchk = 0;
  int            nerr = 0;

  function automatic bit woken(input PRFNum r);
    return (wake_valid[0] && wake_prf[0] == r) || (wake_valid[1] && wake_prf[1] == r);
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    ment_t e;
    int    lat;
    bit    iss;
    bit    acc;
    if (rst) begin
      mq.delete();
      busy.delete();
      exp_vec = NOP_VEC;
      return;
    end
    iss = 1'b0;
    lat = 0;
    if (!flush && mq.size() > 0 && mq[0].r0 && mq[0].r1) begin
      lat = mq[0].dv ? DIV_CYCLE : MUL_CYCLE;
      iss = !busy.exists(cyc + lat) && !busy.exists(cyc + lat + 1);
    end
    acc = enq_valid && (mq.size() < DEPTH) && !flush;
    if (iss) begin
      e = mq[0];
      e.hi.valid = 1'b1;
      e.lo.valid = 1'b1;
      exp_vec = {e.hi, e.lo, e.rs0, e.rs1};
      busy[cyc + 1 + lat] = 1'b1;
      busy[cyc + 2 + lat] = 1'b1;
      m_issues++;
    end else begin
      exp_vec = NOP_VEC;
    end
    foreach (mq[i]) begin
      if (woken(mq[i].rs0)) mq[i].r0 = 1'b1;
      if (woken(mq[i].rs1)) mq[i].r1 = 1'b1;
    end
    if (iss) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
    end else if (acc) begin
      e.hi  = enq_uopHi;
      e.lo  = enq_uopLo;
      e.rs0 = enq_rs0;
      e.rs1 = enq_rs1;
      e.r0  = enq_rs0_rdy || woken(enq_rs0);
      e.r1  = enq_rs1_rdy || woken(enq_rs1);
      e.dv  = (enq_uopLo.uOP inside {DIVLO_U, DIVULO_U});
      mq.push_back(e);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    enq_valid  = 1'b0;
    flush      = 1'b0;
    wake_valid = '0;
    wake_prf   = '0;
  endtask

  task automatic set_enq(input bit dv, input bit uns, input logic [7:0] id,
                         input PRFNum a, input PRFNum b, input bit ra, input bit rb);
    enq_valid       = 1'b1;
    enq_uopHi.valid = 1'b1;
    enq_uopLo.valid = 1'b1;
    enq_uopHi.id    = id;
    enq_uopLo.id    = id;
    if (dv) begin
      enq_uopHi.uOP = uns ? DIVUHI_U : DIVHI_U;
      enq_uopLo.uOP = uns ? DIVULO_U : DIVLO_U;
    end else begin
      enq_uopHi.uOP = uns ? MULTUHI_U : MULTHI_U;
      enq_uopLo.uOP = uns ? MULTULO_U : MULTLO_U;
    end
    enq_rs0     = a;
    enq_rs1     = b;
    enq_rs0_rdy = ra;
    enq_rs1_rdy = rb;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    nchk++;
    if (obs !== NOP_VEC) begin
      nerr++; $display("FAIL reset_outputs: got %h expected %h", obs, NOP_VEC);
    end
    nchk++;
    if (enq_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready);
    end
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    set_enq(1'b0, 1'b0, 8'h01, 6'd1, 6'd2, 1'b1, 1'b1);
    tick();
    idle_inputs();
    tick();
    nchk++;
    if (obs !== exp_vec || uopHi.valid !== 1'b1) begin
      nerr++; $display("FAIL pre_async_issue: got %h expected %h", obs, exp_vec);
    end
    rst = 1'b1;
    #2;
    nchk++;
    if (obs !== NOP_VEC) begin
      nerr++; $display("FAIL async_reset_clear: got %h expected %h", obs, NOP_VEC);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_mult_latency();
    logic exp_v;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 0) set_enq(1'b0, 1'b0, 8'h11, 6'd1, 6'd2, 1'b1, 1'b1);
      else idle_inputs();
      nchk++;
      if (enq_ready !== (mq.size() < DEPTH)) begin
        nerr++; $display("FAIL mult_enq_ready k=%0d: got %b", k, enq_ready);
      end
      tick();
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL mult_out k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      exp_v = (k == 1);
      nchk++;
      if (uopHi.valid !== exp_v || uopLo.valid !== exp_v) begin
        nerr++; $display("FAIL mult_latency k=%0d: got %b%b expected %b", k, uopHi.valid, uopLo.valid, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1; t2 = -1;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      if (k == 0) set_enq(1'b0, 1'b0, 8'h21, 6'd3, 6'd4, 1'b1, 1'b1);
      else if (k == 1) set_enq(1'b0, 1'b1, 8'h22, 6'd5, 6'd6, 1'b1, 1'b1);
      else idle_inputs();
      tick();
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL b2b_out k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      if (uopHi.valid === 1'b1) begin
        if (t1 < 0) t1 = k; else t2 = k;
      end
    end
    nchk++;
    if (t2 - t1 !== 3) begin
      nerr++; $display("FAIL b2b_spacing: got %0d expected 3", t2 - t1);
    end
  endtask

  task automatic test_div_then_mult();
    int td, tm;
    td = -1; tm = -1;
    apply_reset();
    for (int k = 0; k < 26; k++) begin
      idle_inputs();
      if (k == 0) set_enq(1'b1, 1'b0, 8'h31, 6'd1, 6'd2, 1'b1, 1'b1);
      if (k == 1) set_enq(1'b0, 1'b0, 8'h32, 6'd5, 6'd6, 1'b0, 1'b1);
      if (k == 14) begin wake_valid = 2'b01; wake_prf[0] = 6'd5; end
      tick();
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL div_mult_out k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      if (uopLo.valid === 1'b1 && uopLo.uOP == DIVLO_U) td = k;
      if (uopLo.valid === 1'b1 && uopLo.uOP == MULTLO_U) tm = k;
    end
    nchk++;
    if (td < 0 || tm < td + 16) begin
      nerr++; $display("FAIL div_mult_gap: got div=%0d mult=%0d expected mult>=div+16", td, tm);
    end
  endtask

  task automatic test_wakeup();
    logic exp_v;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      if (k == 0) set_enq(1'b0, 1'b0, 8'h41, 6'd3, 6'd7, 1'b1, 1'b0);
      if (k == 3) begin wake_valid = 2'b10; wake_prf[1] = 6'd7; end
      if (k == 6) begin
        set_enq(1'b0, 1'b0, 8'h42, 6'd9, 6'd10, 1'b0, 1'b1);
        wake_valid = 2'b01; wake_prf[0] = 6'd9;
      end
      tick();
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL wake_out k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      exp_v = (k == 4) || (k == 7);
      nchk++;
      if (uopHi.valid !== exp_v) begin
        nerr++; $display("FAIL wake_timing k=%0d: got %b expected %b", k, uopHi.valid, exp_v);
      end
    end
  endtask

  task automatic test_full_flush();
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      idle_inputs();
      if (k == 0) set_enq(1'b1, 1'b0, 8'h50, 6'd1, 6'd2, 1'b1, 1'b1);
      if (k >= 1 && k <= 5)
        set_enq(1'b0, 1'b0, 8'(8'h50 + k), 6'(40 + k), 6'(50 + k), 1'b0, 1'b0);
      if (k == 6) begin
        set_enq(1'b0, 1'b0, 8'h5D, 6'd1, 6'd2, 1'b1, 1'b1);
        flush = 1'b1;
      end
      if (k == 14) set_enq(1'b0, 1'b0, 8'h5E, 6'd11, 6'd12, 1'b1, 1'b1);
      nchk++;
      if (enq_ready !== (mq.size() < DEPTH)) begin
        nerr++; $display("FAIL flush_enq_ready k=%0d: got %b", k, enq_ready);
      end
      if (k == 5 || k == 6) begin
        nchk++;
        if (enq_ready !== 1'b0) begin
          nerr++; $display("FAIL full_blocks k=%0d: got %b expected 0", k, enq_ready);
        end
      end
      if (k == 7) begin
        nchk++;
        if (enq_ready !== 1'b1) begin
          nerr++; $display("FAIL flush_empties: got %b expected 1", enq_ready);
        end
      end
      tick();
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL flush_out k=%0d: got %h expected %h", k, obs, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_v;
    apply_reset();
    for (int k = 0; k < 22; k++) begin
      idle_inputs();
      if (k == 0) set_enq(1'b1, 1'b0, 8'h61, 6'd1, 6'd2, 1'b1, 1'b1);
      if (k >= 1 && k <= 3)
        set_enq(1'b0, 1'b0, 8'(8'h61 + k), 6'(20 + k), 6'(30 + k), 1'b0, 1'b0);
      if (k == 4) begin
        rst = 1'b1;
        #1;
        nchk++;
        if (obs !== NOP_VEC || enq_ready !== 1'b1) begin
          nerr++; $display("FAIL rst_mid_outputs: got %h/%b expected %h/1", obs, enq_ready, NOP_VEC);
        end
      end
      if (k == 8) rst = 1'b0;
      if (k == 16) set_enq(1'b0, 1'b0, 8'h6F, 6'd3, 6'd4, 1'b1, 1'b1);
      tick();
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL rst_mid_out k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      exp_v = (k == 1) || (k == 17);
      nchk++;
      if (uopHi.valid !== exp_v) begin
        nerr++; $display("FAIL rst_mid_timing k=%0d: got %b expected %b", k, uopHi.valid, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int         dut_issues;
    int         base;
    logic [7:0] id;
    dut_issues = 0;
    id = 8'h80;
    apply_reset();
    base = m_issues;
    for (int k = 0; k < 400; k++) begin
      idle_inputs();
      if ($urandom_range(0, 9) < 6) begin
        set_enq($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), id,
                6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        id++;
      end
      wake_valid[0] = ($urandom_range(0, 2) == 0);
      wake_valid[1] = ($urandom_range(0, 2) == 0);
      wake_prf[0]   = 6'($urandom_range(0, 15));
      wake_prf[1]   = 6'($urandom_range(0, 15));
      flush = ($urandom_range(0, 59) == 0);
      nchk++;
      if (enq_ready !== (mq.size() < DEPTH)) begin
        nerr++; $display("FAIL rand_enq_ready k=%0d: got %b", k, enq_ready);
      end
      tick();
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL rand_out k=%0d: got %h expected %h", k, obs, exp_vec);
      end
      if (uopHi.valid === 1'b1) dut_issues++;
    end
    nchk++;
    if (dut_issues !== m_issues - base) begin
      nerr++; $display("FAIL rand_issue_count: got %0d expected %0d", dut_issues, m_issues - base);
    end
  endtask

  initial begin
    test_reset();
    test_mult_latency();
    test_back_to_back();
    test_div_then_mult();
    test_wakeup();
    test_full_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
